// File: rtl/t_latch.sv
// Toggle flip-flop with complement output, toggle pulse and optional toggle counter.
// Define T_LATCH_TOGGLE_CNT_EN to build the counter; otherwise toggle_cnt is tied to zero.
module t_latch #(
   parameter logic        INIT_Q = 1'b0,
   parameter int unsigned CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             T,
   output logic             Q,
   output logic             Qn,
   output logic             toggled,
   output logic [CNT_W-1:0] toggle_cnt
);

   // Power-up values give defined outputs even if rst is never asserted.
   logic q_q       = INIT_Q;
   logic toggled_q = 1'b0;
   logic q_d;
   logic toggled_d;

   // An unknown T takes the else path in simulation, i.e. hold.
   always_comb begin
      q_d       = q_q;
      toggled_d = 1'b0;
      if (T) begin
         q_d       = ~q_q;
         toggled_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q       <= INIT_Q;
         toggled_q <= 1'b0;
      end else begin
         q_q       <= q_d;
         toggled_q <= toggled_d;
      end
   end

   assign Q       = q_q;
   assign Qn      = ~q_q;
   assign toggled = toggled_q;

`ifdef T_LATCH_TOGGLE_CNT_EN
   logic [CNT_W-1:0] cnt_q = '0;
   logic [CNT_W-1:0] cnt_d;

   // Wraps modulo 2^CNT_W by natural overflow.
   always_comb begin
      cnt_d = cnt_q;
      if (toggled_d) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign toggle_cnt = cnt_q;
`else
   assign toggle_cnt = '0;
`endif

endmodule

// File: tb/tb_t_latch.sv
// Directed bench for t_latch: scoreboard of expected Q/toggled/count per clock edge,
// run against a CNT_W=8 and a CNT_W=2 instance sharing the same stimulus.
module tb_t_latch;

   localparam logic InitQ = 1'b0;
`ifdef T_LATCH_TOGGLE_CNT_EN
   localparam bit CntEn = 1'b1;
`else
   localparam bit CntEn = 1'b0;
`endif

   typedef struct packed {
      logic        q;
      logic        tog;
      logic [31:0] cnt;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       t   = 1'b0;
   logic       q8, qn8, tog8;
   logic [7:0] cnt8;
   logic       q2, qn2, tog2;
   logic [1:0] cnt2;

   exp_t        sb_q[$];
   int          n_cmp  = 0;
   int          n_fail = 0;
   logic        m_q    = InitQ;
   logic        m_tog  = 1'b0;
   logic [31:0] m_cnt  = '0;

   always #5 clk = ~clk;

   t_latch #(.INIT_Q(InitQ), .CNT_W(8)) dut8 (
      .clk        (clk),
      .rst        (rst),
      .T          (t),
      .Q          (q8),
      .Qn         (qn8),
      .toggled    (tog8),
      .toggle_cnt (cnt8)
   );

   t_latch #(.INIT_Q(InitQ), .CNT_W(2)) dut2 (
      .clk        (clk),
      .rst        (rst),
      .T          (t),
      .Q          (q2),
      .Qn         (qn2),
      .toggled    (tog2),
      .toggle_cnt (cnt2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare both instances against one expected entry.
   task automatic check_all(input string tag, input exp_t e);
      logic [31:0] c8;
      logic [31:0] c2;
      c8 = CntEn ? {24'd0, e.cnt[7:0]} : 32'd0;
      c2 = CntEn ? {30'd0, e.cnt[1:0]} : 32'd0;
      check({tag, ".q8"},    {31'd0, q8},   {31'd0, e.q});
      check({tag, ".qn8"},   {31'd0, qn8},  {31'd0, ~e.q});
      check({tag, ".tog8"},  {31'd0, tog8}, {31'd0, e.tog});
      check({tag, ".cnt8"},  {24'd0, cnt8}, c8);
      check({tag, ".q2"},    {31'd0, q2},   {31'd0, e.q});
      check({tag, ".qn2"},   {31'd0, qn2},  {31'd0, ~e.q});
      check({tag, ".tog2"},  {31'd0, tog2}, {31'd0, e.tog});
      check({tag, ".cnt2"},  {30'd0, cnt2}, c2);
   endtask

   // Drive at the falling edge, predict, then compare 1 time unit after the rising edge.
   task automatic step(input string tag, input logic t_v, input logic rst_v);
      exp_t e;
      @(negedge clk);
      t   = t_v;
      rst = rst_v;
      if (rst_v) begin
         m_q   = InitQ;
         m_tog = 1'b0;
         m_cnt = '0;
      end else if (t_v) begin
         m_q   = ~m_q;
         m_tog = 1'b1;
         m_cnt = m_cnt + 32'd1;
      end else begin
         m_tog = 1'b0;
      end
      sb_q.push_back('{q: m_q, tog: m_tog, cnt: m_cnt});
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         check({tag, ".sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb_q.pop_front();
         check_all(tag, e);
      end
   endtask

   logic       seq_t[9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
   logic       seq_q[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

   initial begin
      // Time-zero outputs without any reset.
      #1;
      check_all("t0", '{q: InitQ, tog: 1'b0, cnt: 32'd0});

      for (int i = 0; i < 3; i++) step("noreset", 1'b0, 1'b0);

      step("reset", 1'b0, 1'b1);

      // Hold/toggle sequence; also checks Q against the fixed table.
      for (int i = 0; i < 9; i++) begin
         step("seq", seq_t[i], 1'b0);
         check("seq.table", {31'd0, q8}, {31'd0, seq_q[i]});
      end

      // Mid-cycle reset with T=1: nothing moves until the edge, reset wins.
      @(negedge clk);
      rst = 1'b1;
      t   = 1'b1;
      #1;
      check("midrst.q8", {31'd0, q8}, {31'd0, m_q});
      check("midrst.tog8", {31'd0, tog8}, {31'd0, m_tog});
      step("rstprio", 1'b1, 1'b1);
      step("post_rst", 1'b0, 1'b0);

      // Continuous toggle for 4 edges.
      for (int i = 0; i < 4; i++) step("cont", 1'b1, 1'b0);
      step("cont_hold", 1'b0, 1'b0);
      step("cont_hold2", 1'b0, 1'b0);

      check("sb_drained", sb_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule
